// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the register-file writeback scheduler: register index/data
// types and the writeback request record.
package regfile_wb_scheduler_pkg;

   localparam int NUM_WB_SRC = 2;
   localparam int REG_IDX_W  = 5;
   localparam int REG_DATA_W = 32;

   typedef logic [REG_IDX_W-1:0]  reg_index_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   localparam reg_index_t REG_ZERO     = '0;
   localparam reg_data_t  REG_ZERO_VAL = '0;

   typedef struct packed {
      logic       valid;
      reg_index_t rd;
      reg_data_t  data;
   } wb_req_t;

   // x0 is hardwired, so it never takes part in hazard tracking
   function automatic logic is_tracked(input reg_index_t r);
      return r != REG_ZERO;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// Two-way round-robin arbiter; on contention the source that did not win
// last time is granted. Grant is combinational from req.
module rr_arbiter2_m (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = req;
      if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
   end

   // reset to 1 so source 0 wins the first contention
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last_grant <= 1'b1;
      else if (|grant) last_grant <= grant[1];
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: scoreboard of pending destinations with
// RAW/WAW issue stalls, and round-robin arbitration of two writeback sources.
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int REG_COUNT = 32,
   parameter int NUM_WB    = NUM_WB_SRC
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               issue_valid,
   input  logic [4:0]                         issue_rs1,
   input  logic [4:0]                         issue_rs2,
   input  logic                               issue_uses_rs1,
   input  logic                               issue_uses_rs2,
   input  logic [4:0]                         issue_rd,
   input  logic                               issue_writes_rd,
   output logic                               issue_stall,
   input  logic [NUM_WB-1:0]                  wb_valid,
   input  logic [NUM_WB-1:0][4:0]             wb_rd,
   input  logic [NUM_WB-1:0][31:0]            wb_data,
   output logic [NUM_WB-1:0]                  wb_ready,
   output logic                               rf_write_enable,
   output logic [4:0]                         rf_write_reg_addr,
   output logic [31:0]                        rf_write_data,
   output logic [REG_COUNT-1:0]               busy_vec,
   output logic [$clog2(REG_COUNT+1)-1:0]     pending_count,
   output logic                               wb_error
);

   localparam int CNT_W = $clog2(REG_COUNT+1);

   wb_req_t           req [NUM_WB];
   logic [NUM_WB-1:0] req_vld;

   for (genvar i = 0; i < NUM_WB; i++) begin : g_req
      assign req[i]     = '{valid: wb_valid[i], rd: wb_rd[i], data: wb_data[i]};
      assign req_vld[i] = req[i].valid;
   end

   rr_arbiter2_m u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_vld),
      .grant (wb_ready)
   );

   wb_req_t win;
   logic    any_grant;

   always_comb begin
      win = '{valid: 1'b0, rd: REG_ZERO, data: REG_ZERO_VAL};
      for (int i = 0; i < NUM_WB; i++)
         if (wb_ready[i]) win = req[i];
   end

   assign any_grant         = |wb_ready;
   assign rf_write_enable   = any_grant;
   assign rf_write_reg_addr = win.rd;
   assign rf_write_data     = win.data;

   logic                 clr_en, clr_hit, set_en;
   logic                 raw1, raw2, waw;
   logic [REG_COUNT-1:0] clr_vec, set_vec, eff_busy;

   assign clr_en  = any_grant && is_tracked(win.rd);
   assign clr_hit = clr_en && busy_vec[win.rd];

   // the register file forwards this cycle's write, so the target reads as free
   always_comb begin
      clr_vec = '0;
      if (clr_en) clr_vec[win.rd] = 1'b1;
      eff_busy = busy_vec & ~clr_vec;
   end

   assign raw1 = issue_uses_rs1 && is_tracked(issue_rs1) && eff_busy[issue_rs1];
   assign raw2 = issue_uses_rs2 && is_tracked(issue_rs2) && eff_busy[issue_rs2];
   // WAW uses raw busy so a set can never coincide with a legal clear
   assign waw  = issue_writes_rd && is_tracked(issue_rd) && busy_vec[issue_rd];

   assign issue_stall = issue_valid && (raw1 || raw2 || waw);
   assign set_en      = issue_valid && !issue_stall && issue_writes_rd && is_tracked(issue_rd);

   always_comb begin
      set_vec = '0;
      if (set_en) set_vec[issue_rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_vec      <= '0;
         pending_count <= '0;
         wb_error      <= 1'b0;
      end else begin
         busy_vec      <= (busy_vec & ~clr_vec) | set_vec;
         pending_count <= pending_count + CNT_W'(set_en) - CNT_W'(clr_hit);
         if (clr_en && !busy_vec[win.rd]) wb_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a per-register behavioural model.
module tb_regfile_wb_scheduler;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
   logic [4:0]      issue_rs1, issue_rs2, issue_rd;
   logic            issue_stall;
   logic [1:0]      wb_valid, wb_ready;
   logic [1:0][4:0] wb_rd;
   logic [1:0][31:0] wb_data;
   logic            rf_write_enable;
   logic [4:0]      rf_write_reg_addr;
   logic [31:0]     rf_write_data;
   logic [31:0]     busy_vec;
   logic [5:0]      pending_count;
   logic            wb_error;

   int npass = 0;
   int ntot  = 0;

   always #5 clk = ~clk;

   regfile_wb_scheduler dut (
      .clk               (clk),
      .reset             (reset),
      .issue_valid       (issue_valid),
      .issue_rs1         (issue_rs1),
      .issue_rs2         (issue_rs2),
      .issue_uses_rs1    (issue_uses_rs1),
      .issue_uses_rs2    (issue_uses_rs2),
      .issue_rd          (issue_rd),
      .issue_writes_rd   (issue_writes_rd),
      .issue_stall       (issue_stall),
      .wb_valid          (wb_valid),
      .wb_rd             (wb_rd),
      .wb_data           (wb_data),
      .wb_ready          (wb_ready),
      .rf_write_enable   (rf_write_enable),
      .rf_write_reg_addr (rf_write_reg_addr),
      .rf_write_data     (rf_write_data),
      .busy_vec          (busy_vec),
      .pending_count     (pending_count),
      .wb_error          (wb_error)
   );

   // model state: which registers await a write, who won last, error seen
   bit mbusy [32];
   bit mlast;
   bit merr;

   function automatic logic [1:0] m_grant();
      if (wb_valid == 2'b11) return mlast ? 2'b01 : 2'b10;
      return wb_valid;
   endfunction

   function automatic logic [4:0] m_wrd();
      if (m_grant() == 2'b01) return wb_rd[0];
      if (m_grant() == 2'b10) return wb_rd[1];
      return 5'd0;
   endfunction

   function automatic logic [31:0] m_wdata();
      if (m_grant() == 2'b01) return wb_data[0];
      if (m_grant() == 2'b10) return wb_data[1];
      return 32'd0;
   endfunction

   function automatic bit m_free(input logic [4:0] r);
      return !mbusy[r] || (m_grant() != 2'b00 && m_wrd() == r);
   endfunction

   function automatic bit m_stall();
      if (!issue_valid) return 1'b0;
      if (issue_uses_rs1 && issue_rs1 != 0 && !m_free(issue_rs1)) return 1'b1;
      if (issue_uses_rs2 && issue_rs2 != 0 && !m_free(issue_rs2)) return 1'b1;
      if (issue_writes_rd && issue_rd != 0 && mbusy[issue_rd]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_busy_word();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) v[i] = mbusy[i];
      return v;
   endfunction

   function automatic int m_count();
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) if (mbusy[i]) n++;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) mbusy[i] <= 1'b0;
         mlast <= 1'b1;
         merr  <= 1'b0;
      end else begin
         if (m_grant() != 2'b00) begin
            mlast <= (m_grant() == 2'b10);
            if (m_wrd() != 0) begin
               if (!mbusy[m_wrd()]) merr <= 1'b1;
               mbusy[m_wrd()] <= 1'b0;
            end
         end
         if (issue_valid && !m_stall() && issue_writes_rd && issue_rd != 0)
            mbusy[issue_rd] <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      else npass++;
   endtask

   task automatic compare_all();
      chk("issue_stall",  32'(issue_stall),       32'(m_stall()));
      chk("wb_ready",     32'(wb_ready),          32'(m_grant()));
      chk("rf_we",        32'(rf_write_enable),   32'(m_grant() != 2'b00));
      chk("rf_addr",      32'(rf_write_reg_addr), 32'(m_wrd()));
      chk("rf_data",      rf_write_data,          m_wdata());
      chk("busy_vec",     busy_vec,               m_busy_word());
      chk("pending",      32'(pending_count),     32'(m_count()));
      chk("wb_error",     32'(wb_error),          32'(merr));
   endtask

   task automatic idle();
      issue_valid = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_writes_rd = 0;
      issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
      wb_valid = 0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic wr, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2);
      issue_valid = 1; issue_rd = rd; issue_writes_rd = wr;
      issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = rs2; issue_uses_rs2 = u2;
   endtask

   task automatic at_neg();
      @(negedge clk);
      compare_all();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1;
      at_neg();
      chk("rst_busy", busy_vec, 32'h0);
      chk("rst_pend", 32'(pending_count), 32'd0);
      chk("rst_err", 32'(wb_error), 32'd0);
      chk("rst_ready", 32'(wb_ready), 32'd0);
      chk("rst_we", 32'(rf_write_enable), 32'd0);
      adv();
      reset = 0;

      // RAW stall and bypass release
      issue(5, 1, 0, 0, 0, 0);
      at_neg(); chk("t1_issue", 32'(issue_stall), 32'd0);
      adv();
      issue(0, 0, 5, 1, 0, 0);
      at_neg();
      chk("t1_busy", busy_vec, 32'h20);
      chk("t1_pend", 32'(pending_count), 32'd1);
      chk("t1_raw", 32'(issue_stall), 32'd1);
      adv();
      wb_valid = 2'b01; wb_rd[0] = 5; wb_data[0] = 32'hDEADBEEF;
      at_neg();
      chk("t1_ready", 32'(wb_ready), 32'd1);
      chk("t1_we", 32'(rf_write_enable), 32'd1);
      chk("t1_addr", 32'(rf_write_reg_addr), 32'd5);
      chk("t1_data", rf_write_data, 32'hDEADBEEF);
      chk("t1_bypass", 32'(issue_stall), 32'd0);
      adv(); idle();
      at_neg();
      chk("t1_clr", busy_vec, 32'h0);
      adv();

      // round robin; source 1 rd=0 first so source 1 is last winner
      issue(3, 1, 0, 0, 0, 0);
      wb_valid = 2'b10; wb_rd[1] = 0; wb_data[1] = 32'h11;
      at_neg();
      chk("t2_x0_ready", 32'(wb_ready), 32'd2);
      chk("t2_x0_we", 32'(rf_write_enable), 32'd1);
      adv(); idle();
      wb_valid = 2'b11; wb_rd[0] = 3; wb_data[0] = 32'hA0; wb_rd[1] = 0; wb_data[1] = 32'hB1;
      at_neg();
      chk("t2_g1", 32'(wb_ready), 32'd1);
      chk("t2_g1_addr", 32'(rf_write_reg_addr), 32'd3);
      chk("t2_busy3", busy_vec, 32'h8);
      adv();
      wb_rd[0] = 0; wb_data[0] = 32'hC2;
      at_neg();
      chk("t2_g2", 32'(wb_ready), 32'd2);
      chk("t2_g2_data", rf_write_data, 32'hB1);
      chk("t2_clr3", busy_vec, 32'h0);
      adv();
      wb_valid = 2'b01;
      at_neg(); chk("t2_g3", 32'(wb_ready), 32'd1);
      adv(); idle();

      // WAW against an in-flight writeback of the same register
      issue(7, 1, 0, 0, 0, 0);
      at_neg(); adv();
      issue(7, 1, 0, 0, 0, 0);
      wb_valid = 2'b10; wb_rd[1] = 7; wb_data[1] = 32'h77;
      at_neg();
      chk("t3_waw", 32'(issue_stall), 32'd1);
      chk("t3_ready", 32'(wb_ready), 32'd2);
      adv();
      wb_valid = 0;
      at_neg(); chk("t3_nostall", 32'(issue_stall), 32'd0);
      adv(); idle();
      at_neg();
      chk("t3_busy7", busy_vec, 32'h80);
      chk("t3_pend", 32'(pending_count), 32'd1);
      adv();
      wb_valid = 2'b01; wb_rd[0] = 7;
      at_neg(); adv(); idle();

      // spurious writeback sets sticky error
      wb_valid = 2'b01; wb_rd[0] = 9; wb_data[0] = 32'h99;
      at_neg(); chk("t4_pre", 32'(wb_error), 32'd0);
      adv(); idle();
      for (int i = 0; i < 10; i++) begin
         at_neg(); adv();
      end
      at_neg(); chk("t4_sticky", 32'(wb_error), 32'd1);
      adv();
      wb_valid = 2'b10; wb_rd[1] = 0;
      at_neg(); chk("t4_x0_ready", 32'(wb_ready), 32'd2);
      adv(); idle();
      at_neg();
      chk("t4_err_hold", 32'(wb_error), 32'd1);
      chk("t4_busy", busy_vec, 32'h0);
      adv();

      // fill every register, then x0 accesses must not stall
      for (int r = 1; r < 32; r++) begin
         issue(5'(r), 1, 0, 0, 0, 0);
         at_neg(); adv();
      end
      issue(0, 1, 0, 1, 0, 1);
      at_neg(); chk("t5_x0", 32'(issue_stall), 32'd0);
      adv();
      issue(0, 0, 0, 0, 12, 1);
      at_neg();
      chk("t5_rs2", 32'(issue_stall), 32'd1);
      chk("t5_full", busy_vec, 32'hFFFF_FFFE);
      chk("t5_pend", 32'(pending_count), 32'd31);
      adv();
      issue(31, 1, 0, 0, 0, 0);
      at_neg(); chk("t5_waw31", 32'(issue_stall), 32'd1);
      adv(); idle();

      // asynchronous reset between edges
      #2 reset = 1;
      #1;
      chk("t6_busy", busy_vec, 32'h0);
      chk("t6_pend", 32'(pending_count), 32'd0);
      chk("t6_err", 32'(wb_error), 32'd0);
      at_neg(); adv();
      reset = 0;
      wb_valid = 2'b11; wb_rd[0] = 0; wb_rd[1] = 0; wb_data[0] = 32'h5; wb_data[1] = 32'h6;
      at_neg();
      chk("t6_first", 32'(wb_ready), 32'd1);
      chk("t6_data", rf_write_data, 32'h5);
      adv(); idle();
      at_neg();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Controls the shared register file: keeps a scoreboard of destination registers with pending writes and stalls issue on RAW and WAW hazards.
- Arbitrates the register file's single write port between two writeback sources: the ALU pipeline and the multi-cycle load/mul unit.
- Sits between decode/issue, the writeback sources and register_file_m.
- Relies on the register file's same-cycle write-to-read bypass, so a read of a register being written this cycle does not stall.

Parameters:
- REG_COUNT, 32, number of architectural registers; bit 0 (x0) is never busy.
- NUM_WB, 2, number of writeback sources; fixed at 2 in this revision.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- issue_valid  input  1  decode presents an instruction
- issue_rs1  input  5  source register 1 index
- issue_rs2  input  5  source register 2 index
- issue_uses_rs1  input  1  instruction reads rs1
- issue_uses_rs2  input  1  instruction reads rs2
- issue_rd  input  5  destination register index
- issue_writes_rd  input  1  instruction writes rd
- issue_stall  output  1  instruction cannot issue this cycle
- wb_valid  input  2  per-source writeback request
- wb_rd  input  2x5  per-source destination index
- wb_data  input  2x32  per-source write data
- wb_ready  output  2  per-source grant; the request is consumed this cycle
- rf_write_enable  output  1  to register_file_m write_enable
- rf_write_reg_addr  output  5  to register_file_m write_reg_addr
- rf_write_data  output  32  to register_file_m write_data
- busy_vec  output  32  scoreboard bits, debug
- pending_count  output  6  number of set busy bits
- wb_error  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, active-high):
  - busy_vec = 0, pending_count = 0, wb_error = 0.
  - Round-robin pointer last_grant = 1, so source 0 wins first.
  - All combinational outputs follow from this state: issue_stall = 0, wb_ready = 0, rf_write_enable = 0.
- Arbitration (combinational, zero latency):
  - One valid source is granted.
  - If both are valid, grant the source != last_grant.
  - At most one wb_ready bit is high per cycle.
  - On a grant, last_grant <= granted index at the next posedge.
- Register file outputs:
  - rf_write_enable = any grant.
  - rf_write_reg_addr and rf_write_data are the granted source's wb_rd and wb_data.
  - When there is no grant, addr and data are 0.
- Grant to rd = 0:
  - The request is consumed and rf_write_enable is still asserted; the register file drops the write.
  - No scoreboard change and no error.
- Effective busy for hazard checks: busy[r] && !(grant && granted rd == r). A register being written this cycle counts as free because the register file bypasses the write data.
- issue_stall = issue_valid && any of:
  - (uses_rs1 && rs1 != 0 && eff_busy[rs1])
  - (uses_rs2 && rs2 != 0 && eff_busy[rs2])
  - (writes_rd && rd != 0 && busy[rd]); the WAW check uses raw busy, not eff_busy.
- Issue accept (issue_valid && !issue_stall && writes_rd && rd != 0): busy[rd] <= 1.
- Writeback clear: a grant with rd != 0 sets busy[rd] <= 0.
- Same-cycle set and clear on the same rd cannot occur: the WAW stall uses raw busy. A set and a clear on different registers both take effect.
- pending_count is registered and equals popcount(busy_vec) at all times; the register form is next = cur + set - clear.
- wb_error is set on a grant with rd != 0 and busy[rd] == 0, and held until reset.
- Reset mid-operation: the scoreboard is cleared immediately; any writeback in flight is the producer's responsibility to squash.
- Sources hold wb_valid, wb_rd and wb_data stable until wb_ready. Changing them before the grant is undefined.

Decomposition:
- Shared package (system.sv): reg_index_t, reg_data_t, REG_ZERO, REG_ZERO_VAL, plus new typedef wb_req_t {valid, rd, data} and constant NUM_WB_SRC = 2.
- One sub-module: rr_arbiter2_m, a 2-way round-robin arbiter holding the last_grant flop, with inputs req[1:0] and output grant[1:0].
- Scoreboard, hazard logic and counter stay in the top module.

Test Plan:
- Reset, then issue rd=5 writes_rd → busy_vec=0x20, pending_count=1. Next cycle issue rs1=5 → issue_stall=1. Source 0 writeback rd=5 data=0xDEADBEEF → wb_ready=01, rf_write_enable=1, addr=5, data=0xDEADBEEF, and issue_stall=0 in that same cycle via bypass.
- busy[3]=1, both sources valid with rd=3 and rd=0 across three cycles, held until granted → grants alternate 01, 10; source 1 is held until its grant; busy[3] cleared only by the rd=3 grant.
- WAW: busy[7]=1, issue rd=7 while source 1 writes rd=7 this cycle → issue_stall=1; next cycle stall=0 and busy[7] is set again.
- Writeback rd=9 with busy[9]=0 → wb_error=1 and it remains 1 across 10 idle cycles; rd=0 writeback → wb_error unchanged, busy unchanged.
- Issue rd=0 and rs1=0 with everything busy → issue_stall=0, busy_vec unchanged.
- Set busy[1..4], assert reset asynchronously mid-cycle → busy_vec=0, pending_count=0, wb_error=0 before the next clk edge; first grant after reset goes to source 0.
